airlock_pump_ctrl: RTL and testbench

Parametrised pressure-cycle controller for the airlock, succeeding the fixed fill-and-pressurize controller. It drives the fill pump, and optionally an evacuation pump, once both doors are confirmed closed. It holds both door locks for the whole cycle and debounces the pressure sensor over a configurable settle window. It flags a timeout or a door breach as a sticky fault. It sits between the door-interlock logic and the pump drivers in the airlock top level.

---
 rtl/airlock_pkg.sv | 24 ++
 rtl/airlock_settle_cnt.sv | 35 +++
 rtl/airlock_pump_ctrl.sv | 142 ++++++++++++++
 tb/tb_airlock_pump_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock pressure-cycle controller.
// Holds the FSM state encoding, fault codes and the counter-width helper.
// No logic of its own; imported by airlock_pump_ctrl and airlock_settle_cnt.
package airlock_pkg;

    // FSM state encoding (3 bits so EVAC keeps a fixed code whether or not it is built)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FILL  = 3'd1;
    localparam state_t ST_EVAC  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_FAULT = 3'd4;

    // fault_code values; 2'd3 is reserved
    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_TMO  = 2'd1;
    localparam logic [1:0] FLT_DOOR = 2'd2;

    // Width of a counter that must be able to hold max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/airlock_settle_cnt.sv
// Purpose: counts consecutive cycles a pressure sensor reads high; hit flags the settling sample.
// Latency: hit is combinational on the current sample and the registered run length.
// Backpressure: none; clear forces the run back to zero on the next edge.
// Ports: clk, rst_n (async active-low), sensor, clear -> hit.
module airlock_settle_cnt
    import airlock_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int CW            = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    input  logic clear,
    output logic hit
);

    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // hit must not depend on clear: clear is derived from the next state, which uses hit
    assign hit = sensor && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !sensor) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/airlock_pump_ctrl.sv
// Purpose: airlock pressure-cycle FSM driving fill/evac pumps and door locks, with sticky faults.
// Latency: request sampled at edge k drives the pump from edge k; all outputs are registered Moore.
// Backpressure: requests are level-sampled and dropped (not queued) when busy, faulted or doors open.
// Ports: Clock, Reset (async active-low); begin_FandP, begin_Evac, InnerClosed, OuterClosed,
//        Pressurized, Evacuated, clear_fault -> PumpIn, PumpOut, LockDoors, Busy, Done, Fault, fault_code.
// Build option: AIRLOCK_EVAC_EN builds the EVAC state; otherwise begin_Evac/Evacuated are ignored.
module airlock_pump_ctrl
    import airlock_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       begin_FandP,
    input  logic       begin_Evac,
    input  logic       InnerClosed,
    input  logic       OuterClosed,
    input  logic       Pressurized,
    input  logic       Evacuated,
    input  logic       clear_fault,
    output logic       PumpIn,
    output logic       PumpOut,
    output logic       LockDoors,
    output logic       Busy,
    output logic       Done,
    output logic       Fault,
    output logic [1:0] fault_code
);

    localparam int              CW       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [1:0]    code_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          doors_closed, evac_req, evac_at, target, hit;
    logic          req_fill, req_evac, pumping, stay_pumping;

    assign doors_closed = InnerClosed && OuterClosed;

`ifdef AIRLOCK_EVAC_EN
    assign evac_req = begin_Evac;
    assign evac_at  = Evacuated;
    assign pumping  = (state == ST_FILL) || (state == ST_EVAC);
    assign target   = (state == ST_EVAC) ? Evacuated : Pressurized;
`else
    logic unused_evac;
    assign unused_evac = begin_Evac ^ Evacuated;
    assign evac_req    = 1'b0;
    assign evac_at     = 1'b0;
    assign pumping     = (state == ST_FILL);
    assign target      = Pressurized;
`endif

    // Exactly one request with both doors shut is accepted; anything else is dropped
    assign req_fill = begin_FandP && !evac_req && doors_closed;
    assign req_evac = evac_req && !begin_FandP && doors_closed;

    always_comb begin
        state_nxt = state;
        code_nxt  = fault_code;
        case (state)
            ST_IDLE: begin
                if (req_fill)      state_nxt = Pressurized ? ST_DONE : ST_FILL;
                else if (req_evac) state_nxt = evac_at ? ST_DONE : ST_EVAC;
            end
            ST_FILL,
            ST_EVAC: begin
                // breach beats completion, completion beats timeout
                if (!doors_closed) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FLT_DOOR;
                end else if (hit) begin
                    state_nxt = ST_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FLT_TMO;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAULT: begin
                if (clear_fault) begin
                    state_nxt = ST_IDLE;
                    code_nxt  = FLT_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                code_nxt  = FLT_NONE;
            end
        endcase
    end

    // Counters run only while remaining in the same pumping state, so they are zero on every entry
    assign stay_pumping = pumping && (state_nxt == state);

    airlock_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CW            (CW)
    ) u_settle (
        .clk    (Clock),
        .rst_n  (Reset),
        .sensor (target),
        .clear  (!stay_pumping),
        .hit    (hit)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            tmo_cnt    <= '0;
            fault_code <= FLT_NONE;
            PumpIn     <= 1'b0;
            LockDoors  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            tmo_cnt    <= !stay_pumping        ? '0      :
                          (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;
            fault_code <= code_nxt;
            // Outputs decoded from the next state so they line up with the state register
            PumpIn     <= (state_nxt == ST_FILL);
            LockDoors  <= (state_nxt != ST_IDLE);
            Busy       <= (state_nxt == ST_FILL) || (state_nxt == ST_EVAC);
            Done       <= (state_nxt == ST_DONE);
            Fault      <= (state_nxt == ST_FAULT);
        end
    end

`ifdef AIRLOCK_EVAC_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) PumpOut <= 1'b0;
        else        PumpOut <= (state_nxt == ST_EVAC);
    end
`else
    assign PumpOut = 1'b0;
`endif

endmodule

// File: tb/tb_airlock_pump_ctrl.sv
// Bench for airlock_pump_ctrl: decision table from IDLE, hand-written multi-cycle sequences,
// then randomized inputs compared every cycle against a behavioural model.
// Honors AIRLOCK_EVAC_EN the same way the design does.
module tb_airlock_pump_ctrl;

    localparam int S = 3;
    localparam int T = 32;
`ifdef AIRLOCK_EVAC_EN
    localparam bit EVAC_ON = 1'b1;
`else
    localparam bit EVAC_ON = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic       begin_FandP, begin_Evac, InnerClosed, OuterClosed;
    logic       Pressurized, Evacuated, clear_fault;
    logic       PumpIn, PumpOut, LockDoors, Busy, Done, Fault;
    logic [1:0] fault_code;

    always #5 Clock = ~Clock;

    airlock_pump_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .begin_FandP (begin_FandP),
        .begin_Evac  (begin_Evac),
        .InnerClosed (InnerClosed),
        .OuterClosed (OuterClosed),
        .Pressurized (Pressurized),
        .Evacuated   (Evacuated),
        .clear_fault (clear_fault),
        .PumpIn      (PumpIn),
        .PumpOut     (PumpOut),
        .LockDoors   (LockDoors),
        .Busy        (Busy),
        .Done        (Done),
        .Fault       (Fault),
        .fault_code  (fault_code)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {PumpIn, PumpOut, LockDoors, Busy, Done, Fault, fault_code}
    function automatic logic [7:0] outs();
        return {PumpIn, PumpOut, LockDoors, Busy, Done, Fault, fault_code};
    endfunction

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_FILL = 1, M_EVAC = 2, M_DONE = 3, M_FAULT = 4;
    int         m_mode;
    int         m_elapsed;   // pumping cycles completed
    int         m_run;       // consecutive high target samples
    logic [1:0] m_code;

    task automatic model_reset();
        m_mode = M_IDLE; m_elapsed = 0; m_run = 0; m_code = 2'd0;
    endtask

    task automatic model_edge();
        bit doors, ev, tgt;
        doors = InnerClosed && OuterClosed;
        ev    = EVAC_ON && begin_Evac;
        case (m_mode)
            M_IDLE: begin
                if (doors && begin_FandP && !ev) begin
                    m_mode = Pressurized ? M_DONE : M_FILL;
                    m_elapsed = 0; m_run = 0;
                end else if (doors && ev && !begin_FandP) begin
                    m_mode = Evacuated ? M_DONE : M_EVAC;
                    m_elapsed = 0; m_run = 0;
                end
            end
            M_FILL, M_EVAC: begin
                m_elapsed = m_elapsed + 1;
                tgt   = (m_mode == M_FILL) ? Pressurized : Evacuated;
                m_run = tgt ? m_run + 1 : 0;
                if (!doors)             begin m_mode = M_FAULT; m_code = 2'd2; end
                else if (m_run >= S)    m_mode = M_DONE;
                else if (m_elapsed >= T) begin m_mode = M_FAULT; m_code = 2'd1; end
            end
            M_DONE:  m_mode = M_IDLE;
            default: if (clear_fault) begin m_mode = M_IDLE; m_code = 2'd0; end
        endcase
    endtask

    function automatic logic [7:0] model_outs();
        return {m_mode == M_FILL, m_mode == M_EVAC, m_mode != M_IDLE,
                (m_mode == M_FILL) || (m_mode == M_EVAC), m_mode == M_DONE,
                m_mode == M_FAULT, m_code};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    task automatic idle_inputs();
        begin_FandP = 0; begin_Evac = 0; InnerClosed = 1; OuterClosed = 1;
        Pressurized = 0; Evacuated = 0; clear_fault = 0;
    endtask

    task automatic reset_dut();
        @(negedge Clock);
        idle_inputs();
        Reset = 0;
        model_reset();
        #2 Reset = 1;
        @(negedge Clock);
    endtask

    typedef struct {
        logic fandp, evac, inner, outer, press, evacd, clr;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[9];

    int pin, dn, first_done, lock_after;
    bit prev_done;
    bit flip_p, flip_e;
    logic [4:0] glitch;

    initial begin
        idle_inputs();
        Reset = 0;
        model_reset();
        #12;
        chk("reset_state", outs(), 8'h00);
        reset_dut();

        // ---- IDLE decision table: one edge from reset ----
        tbl[0] = '{1,0,1,1,0,0,0, 8'b1011_0000};
        tbl[1] = '{1,0,1,1,1,0,0, 8'b0010_1000};
        tbl[2] = '{1,1,1,1,0,0,0, EVAC_ON ? 8'h00 : 8'b1011_0000};
        tbl[3] = '{1,0,0,1,0,0,0, 8'h00};
        tbl[4] = '{1,0,1,0,0,0,0, 8'h00};
        tbl[5] = '{0,1,1,1,0,0,0, EVAC_ON ? 8'b0111_0000 : 8'h00};
        tbl[6] = '{0,1,1,1,0,1,0, EVAC_ON ? 8'b0010_1000 : 8'h00};
        tbl[7] = '{0,0,1,1,0,0,0, 8'h00};
        tbl[8] = '{0,0,1,1,0,0,1, 8'h00};
        for (int i = 0; i < 9; i++) begin
            reset_dut();
            begin_FandP = tbl[i].fandp; begin_Evac  = tbl[i].evac;
            InnerClosed = tbl[i].inner; OuterClosed = tbl[i].outer;
            Pressurized = tbl[i].press; Evacuated   = tbl[i].evacd;
            clear_fault = tbl[i].clr;
            tick();
            chk($sformatf("table_%0d", i), outs(), tbl[i].exp);
        end

        // ---- Pressurized rises 5 cycles after request and holds ----
        reset_dut();
        begin_FandP = 1; tick(); begin_FandP = 0;
        pin = PumpIn ? 1 : 0; dn = 0; lock_after = -1; prev_done = 0;
        for (int i = 1; i <= 15; i++) begin
            Pressurized = (i >= 5);
            tick();
            if (prev_done && lock_after < 0) lock_after = LockDoors ? 1 : 0;
            if (PumpIn) pin++;
            if (Done) dn++;
            prev_done = Done;
        end
        chk("fill_pump_cycles", pin, 7);
        chk("fill_done_pulses", dn, 1);
        chk("lock_after_done", lock_after, 0);

        // ---- glitch H L H H H: Done only after three consecutive highs ----
        reset_dut();
        glitch = 5'b11101;   // bit i-1 applies before edge k+i
        begin_FandP = 1; tick(); begin_FandP = 0;
        first_done = -1;
        for (int i = 1; i <= 10; i++) begin
            Pressurized = (i > 5) ? 1'b1 : glitch[i-1];
            tick();
            if (Done && first_done < 0) first_done = i;
        end
        chk("glitch_done_edge", first_done, 5);

        // ---- sensor never rises: timeout fault ----
        reset_dut();
        begin_FandP = 1; tick(); begin_FandP = 0;
        pin = PumpIn ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (PumpIn) pin++;
            if (Fault) break;
        end
        chk("timeout_pump_cycles", pin, T);
        chk("timeout_fault", outs(), 8'b0010_0101);
        clear_fault = 1; tick(); clear_fault = 0;
        chk("timeout_clear", outs(), 8'h00);

        // ---- outer door opens on FILL cycle 4: breach fault ----
        reset_dut();
        begin_FandP = 1; tick(); begin_FandP = 0;
        tick(); tick(); tick();
        OuterClosed = 0;
        tick();
        chk("breach_fault", outs(), 8'b0010_0110);
        OuterClosed = 1; begin_FandP = 1;
        tick(); tick(); tick();
        chk("breach_ignores_req", outs(), 8'b0010_0110);
        begin_FandP = 0; clear_fault = 1; tick(); clear_fault = 0;
        chk("breach_clear", outs(), 8'h00);

        // ---- async reset mid-FILL with tmo_cnt at 10 ----
        reset_dut();
        begin_FandP = 1; tick(); begin_FandP = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("prereset_filling", outs(), 8'b1011_0000);
        #2 Reset = 0;
        model_reset();
        #1 chk("async_reset_drop", outs(), 8'h00);
        #1 Reset = 1;
        tick();
        chk("after_reset_idle", outs(), 8'h00);

        // ---- randomized run against the model ----
        reset_dut();
        flip_p = 0; flip_e = 0;
        for (int c = 0; c < 4000; c++) begin
            begin_FandP = ($urandom_range(0, 5) == 0);
            begin_Evac  = ($urandom_range(0, 5) == 0);
            InnerClosed = ($urandom_range(0, 39) != 0);
            OuterClosed = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) == 0) flip_p = !flip_p;
            if ($urandom_range(0, 9) == 0) flip_e = !flip_e;
            Pressurized = flip_p;
            Evacuated   = flip_e;
            clear_fault = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset = 0;
                model_reset();
                #1 chk("rand_async_reset", outs(), 8'h00);
                #1 Reset = 1;
            end
            tick();
            chk("rand_vs_model", outs(), model_outs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
